// File: rtl/addsub_accum_pipe.sv
// Two-stage pipelined add/subtract unit with an accumulator, valid/ready on both sides,
// optional signed saturation and a sticky overflow flag.
module addsub_accum_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sat,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             overflow,
  output logic             carryout,
  output logic             zero,
  output logic             neg,
  output logic             ovf_sticky
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [1:0]       s1_op_q;
  logic             s1_sat_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] z_q;
  logic             ovf_q;
  logic             cout_q;
  logic [WIDTH-1:0] acc_q;
  logic             sticky_q;

  logic             advance;
  logic             accept;
  logic             write;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] z_d;
  logic             carry;
  logic             ovf_d;

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | advance;
  assign accept   = in_valid & in_ready;
  assign write    = s1_valid_q & advance;

  // Subtraction is G + ~B + 1; the carry-in reuses op[0].
  always_comb begin
    g          = s1_op_q[1] ? acc_q : s1_a_q;
    h          = s1_b_q ^ {WIDTH{s1_op_q[0]}};
    {carry, m} = {1'b0, g} + {1'b0, h} + {{WIDTH{1'b0}}, s1_op_q[0]};
    ovf_d      = (g[WIDTH-1] == h[WIDTH-1]) & (m[WIDTH-1] != g[WIDTH-1]);
    z_d        = m;
    if (s1_sat_q && ovf_d) begin
      z_d = g[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_sat_q   <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_op_q    <= op;
      s1_sat_q   <= sat;
    end else if (advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        z_q    <= z_d;
        ovf_q  <= ovf_d;
        cout_q <= carry;
      end
    end
  end

  // clr takes priority over a same-edge accumulator load or sticky set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else if (clr) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else if (write) begin
      acc_q    <= z_d;
      sticky_q <= sticky_q | ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign z          = z_q;
  assign overflow   = ovf_q;
  assign carryout   = cout_q;
  assign zero       = (z_q == '0);
  assign neg        = z_q[WIDTH-1];
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_accum_pipe.sv
// Directed bench for addsub_accum_pipe (WIDTH=8): vector table plus hand-written sequences
// for streaming, back-pressure, clr collisions and asynchronous reset.
module tb_addsub_accum_pipe;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       op = '0;
  logic             sat = 1'b0;
  logic             clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] z;
  logic             overflow;
  logic             carryout;
  logic             zero;
  logic             neg;
  logic             ovf_sticky;

  int checks = 0;
  int failures = 0;

  addsub_accum_pipe #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .sat        (sat),
    .clr        (clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .z          (z),
    .overflow   (overflow),
    .carryout   (carryout),
    .zero       (zero),
    .neg        (neg),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       sat;
    logic [7:0] z;
    logic       ovf;
    logic       co;
    logic       st;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                      input logic tsat);
    int n = 0;
    a = ta; b = tb; op = top; sat = tsat; in_valid = 1'b1;
    while (!in_ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] ez, input logic eovf,
                            input logic eco, input logic est);
    int n = 0;
    while (!out_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_z"}, 32'(z), 32'(ez));
    chk({name, "_ovf"}, 32'(overflow), 32'(eovf));
    chk({name, "_co"}, 32'(carryout), 32'(eco));
    chk({name, "_zero"}, 32'(zero), 32'(ez == 8'h00));
    chk({name, "_neg"}, 32'(neg), 32'(ez[7]));
    chk({name, "_sticky"}, 32'(ovf_sticky), 32'(est));
    @(negedge clk);
  endtask

  initial begin
    //                a      b      op    sat   z      ovf   co    sticky
    vecs[0] = '{8'h7F, 8'h01, 2'd0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h7F, 8'h01, 2'd0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'h01, 2'd1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 2'd1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h07, 8'h05, 2'd1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h03, 8'h03, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h40, 2'd2, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 8'h50, 2'd2, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{8'h00, 8'h01, 2'd3, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{8'hFF, 8'hFF, 2'd0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_flags", {29'd0, overflow, carryout, neg}, 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven single transactions
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sat);
      expect_out($sformatf("v%0d", i), vecs[i].z, vecs[i].ovf, vecs[i].co, vecs[i].st);
    end

    // clr alone clears the sticky flag
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_sticky", 32'(ovf_sticky), 32'd0);

    // Accumulate chain, one transaction per cycle
    a = 8'h00; b = 8'h10; op = 2'd2; sat = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (in_valid) chk($sformatf("chain_ready%0d", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      if (i == 2) in_valid = 1'b0;
      if (i >= 1) begin
        chk($sformatf("chain_valid%0d", i), 32'(out_valid), 32'd1);
        chk($sformatf("chain_z%0d", i), 32'(z), 32'(8'h10 * i));
      end
    end
    @(negedge clk);
    send(8'h00, 8'h30, 2'd3, 1'b0);
    expect_out("chain_sub", 8'h00, 1'b0, 1'b1, 1'b0);

    // clr collision: ACC=0x20, clr on the edge the 0x25 result is written
    send(8'h00, 8'h20, 2'd2, 1'b0);
    expect_out("pre_col", 8'h20, 1'b0, 1'b0, 1'b0);
    a = 8'h00; b = 8'h05; op = 2'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("col_valid", 32'(out_valid), 32'd1);
    chk("col_z", 32'(z), 32'h25);
    chk("col_sticky", 32'(ovf_sticky), 32'd0);
    @(negedge clk);
    send(8'h00, 8'h01, 2'd2, 1'b0);
    expect_out("post_col", 8'h01, 1'b0, 1'b0, 1'b0);

    // clr beats a same-edge sticky set from an overflowing result
    a = 8'h7F; b = 8'h01; op = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("col2_z", 32'(z), 32'h80);
    chk("col2_ovf", 32'(overflow), 32'd1);
    chk("col2_sticky", 32'(ovf_sticky), 32'd0);
    @(negedge clk);
    send(8'h00, 8'h03, 2'd2, 1'b0);
    expect_out("post_col2", 8'h03, 1'b0, 1'b0, 1'b0);

    // Back-pressure: in_valid held for 4 cycles with out_ready low
    begin
      int acc_cnt = 0;
      out_ready = 1'b0; op = 2'd0; b = 8'h00; sat = 1'b0; a = 8'h11; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        logic took;
        took = in_ready;
        @(negedge clk);
        if (took) begin
          acc_cnt++;
          a = a + 8'h11;
        end
      end
      chk("bp_accepted", 32'(acc_cnt), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_z", 32'(z), 32'h11);
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_valid0", 32'(out_valid), 32'd1);
      @(negedge clk);
      chk("bp_valid1", 32'(out_valid), 32'd1);
      chk("bp_z1", 32'(z), 32'h22);
      @(negedge clk);
      chk("bp_drained", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset with two transactions in flight
    out_ready = 1'b0;
    a = 8'h7F; b = 8'h01; op = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    a = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_pre_sticky", 32'(ovf_sticky), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_z", 32'(z), 32'd0);
    chk("ar_zero", 32'(zero), 32'd1);
    chk("ar_sticky", 32'(ovf_sticky), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("ar_no_ghost", 32'(out_valid), 32'd0);
    send(8'h00, 8'h03, 2'd2, 1'b0);
    expect_out("ar_first", 8'h03, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
